gpr_wb_arbiter: RTL and testbench

Shares the single GPR write port between several writeback requesters (ALU path, load/store unit, multi-cycle MUL/DIV or CSR unit) using round-robin arbitration and a registered writeback stage. Also keeps a 32-entry pending-write scoreboard so the issue stage stalls on RAW/WAW hazards. Sits between the execute units and the gpr write port (wr_en/addr/data).

---
 rtl/gpr_wb_arbiter_pkg.sv | 17 +
 rtl/gpr_wb_arbiter_rr_arbiter.sv | 46 ++++
 rtl/gpr_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared constants and helpers for the GPR writeback arbiter.
// Used by gpr_wb_arbiter and rr_arbiter; the register file is fixed at 32 entries.
package gpr_wb_arbiter_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_GPR    = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0_IDX = '0;

    function automatic logic is_x0(input reg_addr_t addr);
        return addr == X0_IDX;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the pointer; the pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_any
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W-1:0] w_cand;
    logic             w_any;

    always_comb begin
        o_grant   = '0;
        w_win_idx = '0;
        w_any     = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_any && i_valid[w_cand]) begin
                w_any            = 1'b1;
                w_win_idx        = w_cand;
                o_grant[w_cand]  = 1'b1;
            end
        end
    end

    assign o_any = w_any;

    // Every grant is a transfer downstream, so the pointer advances on any win.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter with registered writeback stage and pending-write scoreboard.
// Optional macro GPR_WB_BYPASS_EN forwards the writeback value and masks the matching busy.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = DEF_XLEN
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]      req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         gpr_wr_en,
    output logic [REG_ADDR_W-1:0]        gpr_wr_addr,
    output logic [XLEN-1:0]              gpr_wr_data,
    input  logic                         sb_set_en,
    input  logic [REG_ADDR_W-1:0]        sb_set_addr,
    input  logic [REG_ADDR_W-1:0]        sb_rs1_addr,
    input  logic [REG_ADDR_W-1:0]        sb_rs2_addr,
    output logic                         sb_rs1_busy,
    output logic                         sb_rs2_busy,
    output logic                         sb_rd_busy,
    output logic                         byp_rs1_valid,
    output logic                         byp_rs2_valid,
    output logic [XLEN-1:0]              byp_rs1_data,
    output logic [XLEN-1:0]              byp_rs2_data
);

    logic [NUM_REQ-1:0] w_grant;
    logic               w_xfer;
    reg_addr_t          w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;

    logic               r_wr_en;
    reg_addr_t          r_wr_addr;
    logic [XLEN-1:0]    r_wr_data;

    logic [NUM_GPR-1:0] r_pending;
    logic [NUM_GPR-1:0] w_pending_nxt;

    logic               w_rs1_pend;
    logic               w_rs2_pend;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (req_valid),
        .o_grant (w_grant),
        .o_any   (w_xfer)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 are accepted from the requester but never reach the register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer && !is_x0(w_sel_addr);
            if (w_xfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign gpr_wr_en   = r_wr_en;
    assign gpr_wr_addr = r_wr_addr;
    assign gpr_wr_data = r_wr_data;

    // Set is applied after clear so a same-edge re-dispatch keeps the register pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_wr_en) begin
            w_pending_nxt[r_wr_addr] = 1'b0;
        end
        if (sb_set_en) begin
            w_pending_nxt[sb_set_addr] = 1'b1;
        end
        w_pending_nxt[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign w_rs1_pend = r_pending[sb_rs1_addr];
    assign w_rs2_pend = r_pending[sb_rs2_addr];
    assign sb_rd_busy = r_pending[sb_set_addr];

`ifdef GPR_WB_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit     = r_wr_en && (r_wr_addr == sb_rs1_addr) && !is_x0(sb_rs1_addr);
    assign w_rs2_hit     = r_wr_en && (r_wr_addr == sb_rs2_addr) && !is_x0(sb_rs2_addr);
    assign byp_rs1_valid = w_rs1_hit;
    assign byp_rs2_valid = w_rs2_hit;
    assign byp_rs1_data  = r_wr_data;
    assign byp_rs2_data  = r_wr_data;
    assign sb_rs1_busy   = w_rs1_pend && !w_rs1_hit;
    assign sb_rs2_busy   = w_rs2_pend && !w_rs2_hit;
`else
    assign byp_rs1_valid = 1'b0;
    assign byp_rs2_valid = 1'b0;
    assign byp_rs1_data  = '0;
    assign byp_rs2_data  = '0;
    assign sb_rs1_busy   = w_rs1_pend;
    assign sb_rs2_busy   = w_rs2_pend;
`endif

    // Issue must stall on sb_rd_busy unless the pending write retires on this same edge.
    a_no_waw_set: assert property (@(posedge clk) disable iff (!rstn)
        sb_set_en |-> !(r_pending[sb_set_addr] && !(r_wr_en && (r_wr_addr == sb_set_addr))));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed testbench for gpr_wb_arbiter with an expected-writeback queue and
// reference round-robin / scoreboard model; honours GPR_WB_BYPASS_EN if defined.
module tb_gpr_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XL   = 32;
`ifdef GPR_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*XL-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              gpr_wr_en;
    logic [4:0]        gpr_wr_addr;
    logic [XL-1:0]     gpr_wr_data;
    logic              sb_set_en;
    logic [4:0]        sb_set_addr;
    logic [4:0]        sb_rs1_addr;
    logic [4:0]        sb_rs2_addr;
    logic              sb_rs1_busy;
    logic              sb_rs2_busy;
    logic              sb_rd_busy;
    logic              byp_rs1_valid;
    logic              byp_rs2_valid;
    logic [XL-1:0]     byp_rs1_data;
    logic [XL-1:0]     byp_rs2_data;

    typedef struct {
        logic          en;
        logic [4:0]    addr;
        logic [XL-1:0] data;
    } wbExp_t;

    wbExp_t      expQ[$];
    int          modelPtr;
    logic [31:0] modelPending;
    int          checks = 0;
    int          errors = 0;

    gpr_wb_arbiter #(
        .NUM_REQ (NREQ),
        .XLEN    (XL)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .gpr_wr_en     (gpr_wr_en),
        .gpr_wr_addr   (gpr_wr_addr),
        .gpr_wr_data   (gpr_wr_data),
        .sb_set_en     (sb_set_en),
        .sb_set_addr   (sb_set_addr),
        .sb_rs1_addr   (sb_rs1_addr),
        .sb_rs2_addr   (sb_rs2_addr),
        .sb_rs1_busy   (sb_rs1_busy),
        .sb_rs2_busy   (sb_rs2_busy),
        .sb_rd_busy    (sb_rd_busy),
        .byp_rs1_valid (byp_rs1_valid),
        .byp_rs2_valid (byp_rs2_valid),
        .byp_rs1_data  (byp_rs1_data),
        .byp_rs2_data  (byp_rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int idx, input logic [4:0] addr, input logic [XL-1:0] data);
        req_addr[idx*5 +: 5]   = addr;
        req_data[idx*XL +: XL] = data;
    endtask

    task automatic pushIdle();
        wbExp_t e;
        e.en = 1'b0; e.addr = '0; e.data = '0;
        expQ.push_back(e);
    endtask

    // One clock cycle: compare outputs at the falling edge, then queue what the next cycle must show.
    task automatic applyStimulus(input string tag);
        wbExp_t          cur;
        wbExp_t          nxt;
        logic [NREQ-1:0] expGrant;
        logic            hit1;
        logic            hit2;
        int              win;
        int              idx;
        @(negedge clk);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s.queue: observed empty expected entry", tag);
            cur.en = 1'b0; cur.addr = '0; cur.data = '0;
        end else begin
            cur = expQ.pop_front();
        end
        checkOutput({tag, ".wr_en"}, 64'(gpr_wr_en), 64'(cur.en));
        if (cur.en) begin
            checkOutput({tag, ".wr_addr"}, 64'(gpr_wr_addr), 64'(cur.addr));
            checkOutput({tag, ".wr_data"}, 64'(gpr_wr_data), 64'(cur.data));
        end
        hit1 = BYP && cur.en && (cur.addr == sb_rs1_addr) && (sb_rs1_addr != 5'd0);
        hit2 = BYP && cur.en && (cur.addr == sb_rs2_addr) && (sb_rs2_addr != 5'd0);
        checkOutput({tag, ".rs1_busy"}, 64'(sb_rs1_busy), 64'(modelPending[sb_rs1_addr] && !hit1));
        checkOutput({tag, ".rs2_busy"}, 64'(sb_rs2_busy), 64'(modelPending[sb_rs2_addr] && !hit2));
        checkOutput({tag, ".rd_busy"}, 64'(sb_rd_busy), 64'(modelPending[sb_set_addr]));
        checkOutput({tag, ".byp1_v"}, 64'(byp_rs1_valid), 64'(hit1));
        checkOutput({tag, ".byp2_v"}, 64'(byp_rs2_valid), 64'(hit2));
        if (hit1) checkOutput({tag, ".byp1_d"}, 64'(byp_rs1_data), 64'(cur.data));
        if (hit2) checkOutput({tag, ".byp2_d"}, 64'(byp_rs2_data), 64'(cur.data));

        expGrant = '0;
        win      = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (modelPtr + k) % NREQ;
            if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) expGrant[win] = 1'b1;
        checkOutput({tag, ".ready"}, 64'(req_ready), 64'(expGrant));

        if (win >= 0) begin
            nxt.addr = req_addr[win*5 +: 5];
            nxt.data = req_data[win*XL +: XL];
            nxt.en   = (nxt.addr != 5'd0);
            modelPtr = (win + 1) % NREQ;
        end else begin
            nxt.en = 1'b0; nxt.addr = '0; nxt.data = '0;
        end
        expQ.push_back(nxt);

        if (cur.en) modelPending[cur.addr] = 1'b0;
        if (sb_set_en && sb_set_addr != 5'd0) modelPending[sb_set_addr] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [NREQ-1:0] contGrant[6];

    initial begin
        contGrant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rstn        = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
        sb_rs1_addr = '0;
        sb_rs2_addr = '0;
        modelPtr     = 0;
        modelPending = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        checkOutput("reset.wr_en", 64'(gpr_wr_en), 64'd0);
        checkOutput("reset.wr_addr", 64'(gpr_wr_addr), 64'd0);
        checkOutput("reset.wr_data", 64'(gpr_wr_data), 64'd0);
        checkOutput("reset.ready", 64'(req_ready), 64'd0);
        checkOutput("reset.rs1_busy", 64'(sb_rs1_busy), 64'd0);
        pushIdle();

        $display("[TB] single requester");
        setReq(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        applyStimulus("single");
        req_valid = '0;
        applyStimulus("single_wb");

        $display("[TB] write to x0");
        setReq(1, 5'd0, 32'h0000_1234);
        req_valid = 3'b010;
        applyStimulus("x0");
        req_valid = '0;
        applyStimulus("x0_wb");

        $display("[TB] scoreboard set/clear on x7");
        sb_rs1_addr = 5'd7;
        sb_rs2_addr = 5'd3;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd7;
        applyStimulus("sb_set7");
        sb_set_en = 1'b0;
        applyStimulus("sb_hold7");
        applyStimulus("sb_hold7b");
        setReq(2, 5'd7, 32'hCAFE_0007);
        req_valid = 3'b100;
        applyStimulus("sb_wr7");
        req_valid = '0;
        applyStimulus("sb_wb7");
        applyStimulus("sb_clr7");

        $display("[TB] same-edge set and clear on x9");
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        sb_rs2_addr = 5'd9;
        applyStimulus("se_set9");
        sb_set_en = 1'b0;
        setReq(0, 5'd9, 32'h0000_0099);
        req_valid = 3'b001;
        applyStimulus("se_wr9");
        req_valid = '0;
        sb_set_en = 1'b1;
        applyStimulus("se_same_edge");
        sb_set_en = 1'b0;
        applyStimulus("se_after");
        checkOutput("se_rd_busy_hold", 64'(sb_rd_busy), 64'd1);
        setReq(1, 5'd9, 32'h0000_0999);
        req_valid = 3'b010;
        applyStimulus("se_wr9b");
        req_valid = '0;
        applyStimulus("se_wb9b");
        applyStimulus("se_clr");

        $display("[TB] async reset mid-operation, then contention");
        sb_rs1_addr = 5'd13;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd13;
        setReq(0, 5'd10, 32'hA000_000A);
        setReq(1, 5'd11, 32'hB000_000B);
        setReq(2, 5'd12, 32'hC000_000C);
        req_valid = 3'b111;
        applyStimulus("rst_pre");
        sb_set_en = 1'b0;
        applyStimulus("rst_pre2");
        checkOutput("arst.pre_wr_en", 64'(gpr_wr_en), 64'd1);
        #1 rstn = 1'b0;
        #1;
        checkOutput("arst.wr_en", 64'(gpr_wr_en), 64'd0);
        checkOutput("arst.wr_addr", 64'(gpr_wr_addr), 64'd0);
        checkOutput("arst.rs1_busy", 64'(sb_rs1_busy), 64'd0);
        checkOutput("arst.rd_busy", 64'(sb_rd_busy), 64'd0);
        #1 rstn = 1'b1;
        modelPtr     = 0;
        modelPending = '0;
        expQ.delete();
        pushIdle();

        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("cont%0d.grant", c), 64'(req_ready), 64'(contGrant[c]));
            applyStimulus($sformatf("cont%0d", c));
        end
        req_valid = '0;
        applyStimulus("drain");
        applyStimulus("idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
